bitcell_array_ctrl: RTL and testbench

Initiator side of the bitcell access protocol. It takes word-level read/write requests over a valid/ready handshake and drives the shared bitcell-array row interface: per-row select, RW, and the input_bit bus. For reads, it captures the output_bit bus. It sits between the host/bus logic and the bitcell array, and is the only block that drives select/RW.

---
 rtl/bitcell_array_ctrl_pkg.sv | 16 +
 rtl/bitcell_array_ctrl_if.sv | 25 ++
 rtl/bitcell_array_ctrl_row_decoder.sv | 23 ++
 rtl/bitcell_array_ctrl.sv | 126 ++++++++++++
 tb/tb_bitcell_array_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bitcell_array_ctrl_pkg.sv
// Shared definitions for the bitcell array access controller.
package bitcell_array_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Wide enough for ACCESS_CYCLES up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/bitcell_array_ctrl_if.sv
// Host-side request/response handshake of the bitcell array controller.
interface bitcell_array_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/bitcell_array_ctrl_row_decoder.sv
// Row address to one-hot select decoder; all rows low when disabled.
module bitcell_array_ctrl_row_decoder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DEPTH-1:0]  onehot
);

    // Addresses at or beyond DEPTH match no row.
    always_comb begin
        onehot = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (en && (addr == ADDR_W'(i))) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bitcell_array_ctrl.sv
// Initiator for the bitcell array row interface: one word access per
// accepted request, with select held for ACCESS_CYCLES cycles.
module bitcell_array_ctrl
    import bitcell_array_ctrl_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = 4,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    bitcell_array_ctrl_if.slave  bus,
    output logic [DEPTH-1:0]     select,
    output logic                 RW,
    output logic [WIDTH-1:0]     input_bit,
    input  logic [WIDTH-1:0]     output_bit
);

    localparam logic [31:0]      DEPTH_U  = 32'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    state_e             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               req_ready_r;
    logic               rsp_valid_r;
    logic [WIDTH-1:0]   rsp_rdata_r;
    logic               rsp_err_r;
    logic [DEPTH-1:0]   select_r;
    logic               rw_r;
    logic [WIDTH-1:0]   input_bit_r;

    logic               accept_s;
    logic               in_range_s;
    logic [DEPTH-1:0]   row_sel_s;

    assign accept_s   = (state_r == IDLE) && bus.req_valid && req_ready_r;
    assign in_range_s = (32'(bus.req_addr) < DEPTH_U);

    // The decoder is only enabled on the cycle that launches an array access.
    bitcell_array_ctrl_row_decoder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_row_decoder (
        .en     (accept_s && in_range_s),
        .addr   (bus.req_addr),
        .onehot (row_sel_s)
    );

    // Access sequencer: all array and response outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
            select_r    <= {DEPTH{1'b0}};
            rw_r        <= RW_READ;
            input_bit_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    req_ready_r <= 1'b1;
                    if (accept_s) begin
                        req_ready_r <= 1'b0;
                        if (in_range_s) begin
                            state_r     <= ACCESS;
                            select_r    <= row_sel_s;
                            rw_r        <= bus.req_we ? RW_WRITE : RW_READ;
                            input_bit_r <= bus.req_we ? bus.req_wdata : {WIDTH{1'b0}};
                            cnt_r       <= CNT_LOAD;
                        end else begin
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= {WIDTH{1'b0}};
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        rsp_rdata_r <= (rw_r == RW_WRITE) ? {WIDTH{1'b0}} : output_bit;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        select_r    <= {DEPTH{1'b0}};
                        rw_r        <= RW_READ;
                        input_bit_r <= {WIDTH{1'b0}};
                        state_r     <= RESP;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= {WIDTH{1'b0}};
                        rsp_err_r   <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= {WIDTH{1'b0}};
                    rsp_err_r   <= 1'b0;
                    select_r    <= {DEPTH{1'b0}};
                    rw_r        <= RW_READ;
                    input_bit_r <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign select        = select_r;
    assign RW            = rw_r;
    assign input_bit     = input_bit_r;

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Bench for bitcell_array_ctrl: a transaction-phase model with a scoreboard
// memory is compared every cycle, plus directed literal checks.
module tb_bitcell_array_ctrl;

    localparam int W   = 8;
    localparam int D   = 16;
    localparam int AW  = 4;
    localparam int AC  = 2;
    localparam int D2  = 12;
    localparam int AC2 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bitcell_array_ctrl_if #(.WIDTH(W), .ADDR_W(AW)) bus  ();
    bitcell_array_ctrl_if #(.WIDTH(W), .ADDR_W(AW)) bus2 ();

    logic [D-1:0]  select;
    logic          rw;
    logic [W-1:0]  input_bit;
    logic [W-1:0]  output_bit;
    logic [D2-1:0] select2;
    logic          rw2;
    logic [W-1:0]  input_bit2;
    logic [W-1:0]  output_bit2;

    bitcell_array_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst(rst), .bus(bus), .select(select), .RW(rw),
        .input_bit(input_bit), .output_bit(output_bit)
    );

    bitcell_array_ctrl #(.WIDTH(W), .DEPTH(D2), .ADDR_W(AW), .ACCESS_CYCLES(AC2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .select(select2), .RW(rw2),
        .input_bit(input_bit2), .output_bit(output_bit2)
    );

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Physical array: rows written while selected with RW=1, read data shown while selected.
    logic [W-1:0] init_val [D];
    logic [W-1:0] arr [D];
    always @(posedge clk) begin
        for (int i = 0; i < D; i++) begin
            if (rst) arr[i] <= init_val[i];
            else if (select[i] && rw) arr[i] <= input_bit;
        end
    end
    always_comb begin
        output_bit = 8'h00;
        for (int i = 0; i < D; i++) if (select[i]) output_bit = arr[i];
    end
    assign output_bit2 = (select2 != 12'h000) ? 8'h3C : 8'h00;

    // Reference model: transaction phase tracked by age since acceptance.
    logic         m_busy, m_rspv, m_err, m_rdy, m_we;
    logic [AW-1:0] m_addr;
    logic [W-1:0] m_wdata, m_rdata;
    int           m_age;
    logic [W-1:0] sb [D];
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_rspv <= 1'b0; m_err <= 1'b0; m_rdy <= 1'b0;
            m_rdata <= 8'h00; m_age <= 0;
            for (int i = 0; i < D; i++) sb[i] <= init_val[i];
        end else if (!m_busy) begin
            m_rdy <= 1'b1;
            if (bus.req_valid && m_rdy) begin
                m_rdy <= 1'b0; m_busy <= 1'b1; m_age <= 1;
                m_we <= bus.req_we; m_addr <= bus.req_addr; m_wdata <= bus.req_wdata;
                if (int'(bus.req_addr) >= D) begin
                    m_rspv <= 1'b1; m_err <= 1'b1;
                end
            end
        end else if (m_rspv) begin
            if (bus.rsp_ready) begin
                m_rspv <= 1'b0; m_err <= 1'b0; m_rdata <= 8'h00;
                m_busy <= 1'b0; m_rdy <= 1'b1;
            end
        end else begin
            m_age <= m_age + 1;
            if (m_age == AC) begin
                m_rspv  <= 1'b1;
                m_rdata <= m_we ? 8'h00 : sb[m_addr];
                if (m_we) sb[m_addr] <= m_wdata;
            end
        end
    end

    logic [D-1:0] one16 = 16'h0001;
    logic [D-1:0] exp_sel;
    always_comb exp_sel = (m_busy && !m_rspv) ? (one16 << m_addr) : 16'h0000;

    // Every-cycle comparison of the main DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("select", select, exp_sel);
            chk("rw", rw, (exp_sel != 16'h0000) && m_we);
            chk("input_bit", input_bit, ((exp_sel != 16'h0000) && m_we) ? m_wdata : 8'h00);
            chk("req_ready", bus.req_ready, m_rdy);
            chk("rsp_valid", bus.rsp_valid, m_rspv);
            chk("rsp_rdata", bus.rsp_rdata, m_rdata);
            chk("rsp_err", bus.rsp_err, m_err);
            chk("onehot_select", $onehot0(select), 1'b1);
            chk("rw_needs_select", (!rw) || (select != 16'h0000), 1'b1);
        end
    end

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
        while (bus.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("req_ready_timeout", bus.req_ready, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_addr = 4'($urandom);
        bus.req_wdata = 8'($urandom);
    endtask

    task automatic take_rsp(input int hold);
        int n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("rsp_valid_timeout", bus.rsp_valid, 1'b1);
        repeat (hold) begin
            @(negedge clk);
            chk("ready_low_in_resp", bus.req_ready, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic issue2(input logic [AW-1:0] a);
        int n = 0;
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_addr = a; bus2.req_wdata = 8'h00;
        while (bus2.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("req2_ready_timeout", bus2.req_ready, 1'b1);
        @(negedge clk);
        bus2.req_valid = 1'b0;
    endtask

    task automatic ack2();
        bus2.rsp_ready = 1'b1;
        @(negedge clk);
        bus2.rsp_ready = 1'b0;
        chk("dut2_rsp_cleared", {bus2.rsp_valid, bus2.rsp_err, bus2.rsp_rdata}, 10'h000);
    endtask

    initial begin
        for (int i = 0; i < D; i++) init_val[i] = 8'($urandom);
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 4'h0; bus.req_wdata = 8'h00;
        bus.rsp_ready = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = 4'h0; bus2.req_wdata = 8'h00;
        bus2.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_req_ready", bus.req_ready, 1'b0);
        chk("reset_select", select, 16'h0000);
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.req_ready, 1'b1);

        // Write row 3.
        issue(1'b1, 4'd3, 8'hA5);
        chk("wr_select_c1", select, 16'h0008);
        chk("wr_rw_c1", rw, 1'b1);
        chk("wr_input_c1", input_bit, 8'hA5);
        @(negedge clk);
        chk("wr_select_c2", select, 16'h0008);
        chk("wr_input_c2", input_bit, 8'hA5);
        @(negedge clk);
        chk("wr_select_done", select, 16'h0000);
        chk("wr_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b1, 1'b0, 8'h00});
        take_rsp(0);

        // Read row 3 back.
        issue(1'b0, 4'd3, 8'h00);
        chk("rd_select_c1", select, 16'h0008);
        chk("rd_rw_c1", rw, 1'b0);
        @(negedge clk);
        chk("rd_select_c2", select, 16'h0008);
        @(negedge clk);
        chk("rd_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b1, 1'b0, 8'hA5});
        take_rsp(0);

        // Read row 0 with a stalled response, then row 15.
        issue(1'b0, 4'd0, 8'h00);
        take_rsp(3);
        issue(1'b0, 4'd15, 8'h00);
        chk("rd15_select", select, 16'h8000);
        take_rsp(1);

        // Reset during the second access cycle.
        issue(1'b0, 4'd5, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_select", select, 16'h0000);
        chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", bus.req_ready, 1'b1);

        // Twelve-row instance: out-of-range and last-row accesses.
        issue2(4'd13);
        chk("err13_select", select2, 12'h000);
        chk("err13_rsp", {bus2.rsp_valid, bus2.rsp_err, bus2.rsp_rdata}, {1'b1, 1'b1, 8'h00});
        ack2();
        issue2(4'd11);
        chk("rd11_select", select2, 12'h800);
        chk("rd11_rsp_pending", bus2.rsp_valid, 1'b0);
        @(negedge clk);
        chk("rd11_select_done", select2, 12'h000);
        chk("rd11_rsp", {bus2.rsp_valid, bus2.rsp_err, bus2.rsp_rdata}, {1'b1, 1'b0, 8'h3C});
        ack2();
        issue2(4'd12);
        chk("err12_select", select2, 12'h000);
        chk("err12_rsp", {bus2.rsp_valid, bus2.rsp_err, bus2.rsp_rdata}, {1'b1, 1'b1, 8'h00});
        ack2();

        // Random read/write mix.
        for (int t = 0; t < 500; t++) begin
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, D - 1)), 8'($urandom));
            take_rsp(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
